muldiv_unit: RTL and testbench

Iterative RV64M multiply/divide execute unit directly downstream of the 64-bit register file.
- Consumes the two source operands read from rs1/rs2 plus the destination index rd.
- Produces a 64-bit result and rd tag for the register file write port.
- Valid/ready handshake on both sides lets the pipeline stall while the unit iterates.

---
 rtl/muldiv_pkg.sv | 30 +++
 rtl/muldiv_if.sv | 28 ++
 rtl/muldiv_core_step.sv | 38 +++
 rtl/muldiv_unit.sv | 242 ++++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared opcode encodings, FSM state type and special-case result constants
// for the iterative RV64M multiply/divide unit.
package muldiv_pkg;

   localparam int XLEN_DEF  = 64;
   localparam int TAG_W_DEF = 5;

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_DIVU   = 3'd5;
   localparam logic [2:0] OP_REM    = 3'd6;
   localparam logic [2:0] OP_REMU   = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic [XLEN_DEF-1:0] DIV0_QUOTIENT = {XLEN_DEF{1'b1}};
   localparam logic [XLEN_DEF-1:0] OVF_REMAINDER = {XLEN_DEF{1'b0}};

   function automatic logic [63:0] sext32(input logic [31:0] x);
      return {{32{x[31]}}, x};
   endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response handshake bundle between the register file stage and the
// muldiv unit; master drives requests and accepts results.
interface muldiv_if #(
   parameter int XLEN  = 64,
   parameter int TAG_W = 5
) ();
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       in_op;
   logic             in_word;
   logic [XLEN-1:0]  in_a;
   logic [XLEN-1:0]  in_b;
   logic [TAG_W-1:0] in_rd;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_result;
   logic [TAG_W-1:0] out_rd;

   modport master (
      output in_valid, in_op, in_word, in_a, in_b, in_rd, out_ready,
      input  in_ready, out_valid, out_result, out_rd
   );

   modport slave (
      input  in_valid, in_op, in_word, in_a, in_b, in_rd, out_ready,
      output in_ready, out_valid, out_result, out_rd
   );
endinterface

// File: rtl/muldiv_core_step.sv
// One iteration of the muldiv datapath: radix-2 shift-add for multiply,
// restore-subtract for divide. {hi,lo} is the working double-width register.
module muldiv_core_step #(
   parameter int XLEN = 64
) (
   input  logic            is_div,
   input  logic [XLEN-1:0] hi,
   input  logic [XLEN-1:0] lo,
   input  logic [XLEN-1:0] opnd,
   output logic [XLEN-1:0] hi_next,
   output logic [XLEN-1:0] lo_next
);
   logic [XLEN:0]   sum_s;
   logic [XLEN:0]   rem_sh_s;
   logic [XLEN-1:0] diff_s;
   logic            ge_s;

   // Shifted remainder can exceed XLEN bits, so compare at XLEN+1 and keep the low difference
   always_comb begin
      sum_s    = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
      rem_sh_s = {hi, lo[XLEN-1]};
      ge_s     = (rem_sh_s >= {1'b0, opnd});
      diff_s   = rem_sh_s[XLEN-1:0] - opnd;
      if (is_div) begin
         if (ge_s) begin
            hi_next = diff_s;
            lo_next = {lo[XLEN-2:0], 1'b1};
         end else begin
            hi_next = rem_sh_s[XLEN-1:0];
            lo_next = {lo[XLEN-2:0], 1'b0};
         end
      end else begin
         hi_next = sum_s[XLEN:1];
         lo_next = {sum_s[0], lo[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide execute unit with valid/ready handshakes.
// Define MULDIV_WORD_OPS_EN to enable the W-variant (32-bit) operations.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int TAG_W = TAG_W_DEF
) (
   input logic     clk,
   input logic     rst_n,
   muldiv_if.slave bus
);
   localparam int HALF  = XLEN / 2;
   localparam int CNT_W = $clog2(XLEN);

   state_e           state_r, state_next_s;
   logic [2:0]       op_r;
   logic             word_r, neg_r;
   logic [XLEN-1:0]  hi_r, lo_r, opnd_r;
   logic [CNT_W-1:0] cnt_r, cnt_last_s;
   logic [XLEN-1:0]  hi_step_s, lo_step_s;

   logic             in_ready_r, out_valid_r;
   logic [XLEN-1:0]  out_result_r;
   logic [TAG_W-1:0] out_rd_r;
   logic             in_ready_d_s, out_valid_d_s;
   logic [XLEN-1:0]  out_result_d_s;
   logic [TAG_W-1:0] out_rd_d_s;

   logic             accept_s, word_s, is_div_s, is_rem_s, illegal_s;
   logic             a_signed_s, b_signed_s, sign_a_s, sign_b_s, neg_s;
   logic             b_zero_s, ovf_s, fast_s;
   logic [XLEN-1:0]  a_ext_s, b_ext_s, mag_a_s, mag_b_s, min_neg_s;
   logic [XLEN-1:0]  fast_res_s, lo_ld_s, opnd_ld_s, done_res_s;

`ifdef MULDIV_WORD_OPS_EN
   assign word_s = bus.in_word;
`else
   assign word_s = bus.in_word & 1'b0;
`endif

   assign accept_s   = bus.in_valid & in_ready_r;
   assign cnt_last_s = word_r ? CNT_W'(HALF - 1) : CNT_W'(XLEN - 1);

   // Apply result sign and select the requested half / quotient / remainder
   function automatic logic [XLEN-1:0] fixup(
      input logic [2:0]      op,
      input logic            word,
      input logic            neg,
      input logic [XLEN-1:0] hi,
      input logic [XLEN-1:0] lo
   );
      logic [2*XLEN-1:0] prod;
      logic [XLEN-1:0]   x;
      prod = neg ? -{hi, lo} : {hi, lo};
      if (op[2]) begin
         x = op[1] ? hi : lo;
      end else begin
         x = {{HALF{1'b0}}, lo[XLEN-1:HALF]};
      end
      if (neg) begin
         x = -x;
      end else begin
         x = x;
      end
      if (word) begin
         return sext32(x[HALF-1:0]);
      end else if (op[2]) begin
         return x;
      end else begin
         return (op[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      end
   endfunction

   // Request decode: operand extension, magnitudes, signs and fast-path detection
   always_comb begin
      is_div_s   = bus.in_op[2];
      is_rem_s   = bus.in_op[2] & bus.in_op[1];
      illegal_s  = word_s & ~bus.in_op[2] & (bus.in_op[1:0] != 2'b00);
      a_signed_s = (bus.in_op == OP_MULH) | (bus.in_op == OP_MULHSU) |
                   (bus.in_op == OP_DIV)  | (bus.in_op == OP_REM);
      b_signed_s = (bus.in_op == OP_MULH) | (bus.in_op == OP_DIV) | (bus.in_op == OP_REM);
      if (word_s) begin
         a_ext_s   = a_signed_s ? sext32(bus.in_a[HALF-1:0]) : {{HALF{1'b0}}, bus.in_a[HALF-1:0]};
         b_ext_s   = b_signed_s ? sext32(bus.in_b[HALF-1:0]) : {{HALF{1'b0}}, bus.in_b[HALF-1:0]};
         min_neg_s = sext32(32'h8000_0000);
      end else begin
         a_ext_s   = bus.in_a;
         b_ext_s   = bus.in_b;
         min_neg_s = {1'b1, {(XLEN-1){1'b0}}};
      end
      sign_a_s  = a_signed_s & a_ext_s[XLEN-1];
      sign_b_s  = b_signed_s & b_ext_s[XLEN-1];
      mag_a_s   = sign_a_s ? -a_ext_s : a_ext_s;
      mag_b_s   = sign_b_s ? -b_ext_s : b_ext_s;
      neg_s     = is_rem_s ? sign_a_s : (sign_a_s ^ sign_b_s);
      b_zero_s  = (b_ext_s == {XLEN{1'b0}});
      ovf_s     = is_div_s & b_signed_s & (a_ext_s == min_neg_s) & (b_ext_s == {XLEN{1'b1}});
      fast_s    = illegal_s | (is_div_s & b_zero_s) | ovf_s;
      if (illegal_s) begin
         fast_res_s = {XLEN{1'b0}};
      end else if (b_zero_s) begin
         fast_res_s = is_rem_s ? (word_s ? sext32(bus.in_a[HALF-1:0]) : bus.in_a) : DIV0_QUOTIENT;
      end else begin
         fast_res_s = is_rem_s ? OVF_REMAINDER : a_ext_s;
      end
      // Word divides start with the dividend in the upper half so its MSB shifts out first
      lo_ld_s   = is_div_s ? (word_s ? {mag_a_s[HALF-1:0], {HALF{1'b0}}} : mag_a_s) : mag_b_s;
      opnd_ld_s = is_div_s ? mag_b_s : mag_a_s;
   end

   muldiv_core_step #(.XLEN(XLEN)) u_step (
      .is_div  (op_r[2]),
      .hi      (hi_r),
      .lo      (lo_r),
      .opnd    (opnd_r),
      .hi_next (hi_step_s),
      .lo_next (lo_step_s)
   );

   assign done_res_s = fixup(op_r, word_r, neg_r, hi_step_s, lo_step_s);

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_next_s = fast_s ? ST_DONE : ST_BUSY;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (cnt_r == cnt_last_s) begin
               state_next_s = ST_DONE;
            end else begin
               state_next_s = ST_BUSY;
            end
         end
         ST_DONE: begin
            if (bus.out_ready) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_DONE;
            end
         end
         default: state_next_s = ST_IDLE;
      endcase
   end

   // FSM output logic: next values of the registered handshake outputs
   always_comb begin
      in_ready_d_s   = (state_next_s == ST_IDLE);
      out_valid_d_s  = (state_next_s == ST_DONE);
      out_result_d_s = out_result_r;
      out_rd_d_s     = out_rd_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               out_rd_d_s     = bus.in_rd;
               out_result_d_s = fast_s ? fast_res_s : out_result_r;
            end else begin
               out_rd_d_s     = out_rd_r;
            end
         end
         ST_BUSY: begin
            if (cnt_r == cnt_last_s) begin
               out_result_d_s = done_res_s;
            end else begin
               out_result_d_s = out_result_r;
            end
         end
         default: out_result_d_s = out_result_r;
      endcase
   end

   // Output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_ready_r   <= 1'b1;
         out_valid_r  <= 1'b0;
         out_result_r <= {XLEN{1'b0}};
         out_rd_r     <= {TAG_W{1'b0}};
      end else begin
         in_ready_r   <= in_ready_d_s;
         out_valid_r  <= out_valid_d_s;
         out_result_r <= out_result_d_s;
         out_rd_r     <= out_rd_d_s;
      end
   end

   // Operand capture on accept and one datapath iteration per BUSY cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_r   <= 3'd0;
         word_r <= 1'b0;
         neg_r  <= 1'b0;
         hi_r   <= {XLEN{1'b0}};
         lo_r   <= {XLEN{1'b0}};
         opnd_r <= {XLEN{1'b0}};
         cnt_r  <= {CNT_W{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  op_r   <= bus.in_op;
                  word_r <= word_s;
                  neg_r  <= neg_s;
                  hi_r   <= {XLEN{1'b0}};
                  lo_r   <= lo_ld_s;
                  opnd_r <= opnd_ld_s;
                  cnt_r  <= {CNT_W{1'b0}};
               end
            end
            ST_BUSY: begin
               hi_r  <= hi_step_s;
               lo_r  <= lo_step_s;
               cnt_r <= cnt_r + CNT_W'(1);
            end
            default: begin
               cnt_r <= cnt_r;
            end
         endcase
      end
   end

   assign bus.in_ready   = in_ready_r;
   assign bus.out_valid  = out_valid_r;
   assign bus.out_result = out_result_r;
   assign bus.out_rd     = out_rd_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed, table-driven bench for muldiv_unit plus backpressure and
// mid-operation reset sequences. Word-op vectors follow MULDIV_WORD_OPS_EN.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   logic clk;
   logic rst_n;
   int   pass_cnt;
   int   total_cnt;

   muldiv_if #(.XLEN(64), .TAG_W(5)) bus ();

   muldiv_unit #(.XLEN(64), .TAG_W(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [2:0]  op;
      logic        word;
      logic [63:0] a;
      logic [63:0] b;
      logic [4:0]  rd;
      logic [63:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act !== exp) begin
         $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
      end else begin
         pass_cnt++;
      end
   endtask

   task automatic add(input string name, input logic [2:0] op, input logic word,
                      input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                      input logic [63:0] exp, input int lat);
      vec_t v;
      v.name = name; v.op = op; v.word = word; v.a = a; v.b = b;
      v.rd = rd; v.exp = exp; v.lat = lat;
      vecs.push_back(v);
   endtask

   task automatic run_op(input vec_t v);
      int lat;
      int waitc;
      @(negedge clk);
      bus.in_op    = v.op;
      bus.in_word  = v.word;
      bus.in_a     = v.a;
      bus.in_b     = v.b;
      bus.in_rd    = v.rd;
      bus.in_valid = 1'b1;
      waitc = 0;
      while (!bus.in_ready && waitc < 10) begin
         @(negedge clk);
         waitc++;
      end
      check({v.name, "_in_ready"}, {63'd0, bus.in_ready}, 64'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!bus.out_valid && lat < 200);
      check({v.name, "_result"}, bus.out_result, v.exp);
      check({v.name, "_rd"}, {59'd0, bus.out_rd}, {59'd0, v.rd});
      check({v.name, "_latency"}, 64'(lat), 64'(v.lat));
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
   endtask

   initial begin
      int bad;
      int seen;
      int i;
      vec_t v;
      pass_cnt       = 0;
      total_cnt      = 0;
      rst_n          = 1'b0;
      bus.in_valid   = 1'b0;
      bus.in_op      = 3'd0;
      bus.in_word    = 1'b0;
      bus.in_a       = 64'd0;
      bus.in_b       = 64'd0;
      bus.in_rd      = 5'd0;
      bus.out_ready  = 1'b0;

      add("mul",      OP_MUL,    1'b0, 64'd17600, 64'd298700, 5'd1, 64'd5257120000, 65);
      add("divu",     OP_DIVU,   1'b0, 64'd298700, 64'd17600, 5'd2, 64'd16, 65);
      add("remu",     OP_REMU,   1'b0, 64'd298700, 64'd17600, 5'd3, 64'd17100, 65);
      add("div_by0",  OP_DIV,    1'b0, 64'd999, 64'd0, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF, 1);
      add("rem_by0",  OP_REM,    1'b0, 64'd999, 64'd0, 5'd5, 64'd999, 1);
      add("div_ovf",  OP_DIV,    1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd6,
          64'h8000_0000_0000_0000, 1);
      add("rem_ovf",  OP_REM,    1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7,
          64'd0, 1);
      add("mulhu",    OP_MULHU,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd8,
          64'hFFFF_FFFF_FFFF_FFFE, 65);
      add("mulh_m1",  OP_MULH,   1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd10,
          64'd0, 65);
      add("div_neg",  OP_DIV,    1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd11,
          64'hFFFF_FFFF_FFFF_FFFD, 65);
      add("rem_neg",  OP_REM,    1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd12,
          64'hFFFF_FFFF_FFFF_FFFF, 65);
      add("mulhsu",   OP_MULHSU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd13,
          64'hFFFF_FFFF_FFFF_FFFF, 65);
      add("mul_neg",  OP_MUL,    1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 5'd14,
          64'hFFFF_FFFF_FFFF_FFF1, 65);
      add("mulh_min", OP_MULH,   1'b0, 64'h8000_0000_0000_0000, 64'd2, 5'd15,
          64'hFFFF_FFFF_FFFF_FFFF, 65);
      add("divu_by0", OP_DIVU,   1'b0, 64'd5, 64'd0, 5'd16, 64'hFFFF_FFFF_FFFF_FFFF, 1);
`ifdef MULDIV_WORD_OPS_EN
      add("divw",     OP_DIV,    1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'd3, 5'd17,
          64'hFFFF_FFFF_FFFF_FFFE, 33);
      add("mulw",     OP_MUL,    1'b1, 64'h0000_0001_0000_C000, 64'h0000_0000_0002_0000, 5'd18,
          64'hFFFF_FFFF_8000_0000, 33);
      add("remuw",    OP_REMU,   1'b1, 64'hFFFF_FFFF_0000_0007, 64'd3, 5'd19, 64'd1, 33);
      add("remuw_0",  OP_REMU,   1'b1, 64'h0000_0000_8000_0005, 64'hABCD_0000_0000_0000, 5'd20,
          64'hFFFF_FFFF_8000_0005, 1);
      add("divw_ovf", OP_DIV,    1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd22,
          64'hFFFF_FFFF_8000_0000, 1);
      add("mulhw_ill", OP_MULH,  1'b1, 64'd7, 64'd9, 5'd23, 64'd0, 1);
`else
      add("div_word_ign", OP_DIV,  1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'd3, 5'd17,
          64'hFFFF_FFFF_FFFF_FFFE, 65);
      add("mulh_word_ign", OP_MULH, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd18,
          64'd0, 65);
`endif

      repeat (3) @(negedge clk);
      check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
      check("rst_out_valid_rel", {63'd0, bus.out_valid}, 64'd0);
      check("rst_out_result", bus.out_result, 64'd0);
      check("rst_out_rd", {59'd0, bus.out_rd}, 64'd0);

      foreach (vecs[k]) begin
         run_op(vecs[k]);
      end

      // Backpressure: spurious in_valid and out_ready while busy, then 10 stalled DONE cycles
      @(negedge clk);
      bus.in_op = OP_MUL; bus.in_word = 1'b0; bus.in_a = 64'd6; bus.in_b = 64'd7;
      bus.in_rd = 5'd9; bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_a = 64'd100; bus.in_b = 64'd100; bus.in_rd = 5'd3;
      i = 0;
      while (!bus.out_valid && i < 200) begin
         @(negedge clk);
         if (i == 3) bus.out_ready = 1'b1;
         if (i == 5) bus.in_valid = 1'b0;
         if (i == 8) bus.out_ready = 1'b0;
         i++;
      end
      check("bp_out_valid", {63'd0, bus.out_valid}, 64'd1);
      check("bp_result", bus.out_result, 64'd42);
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (bus.out_result !== 64'd42 || bus.out_rd !== 5'd9 ||
             bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) bad++;
      end
      check("bp_stable_cycles_bad", 64'(bad), 64'd0);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      @(negedge clk);
      check("bp_idle_out_valid", {63'd0, bus.out_valid}, 64'd0);
      check("bp_idle_in_ready", {63'd0, bus.in_ready}, 64'd1);

      // Reset in the middle of an iterating divide
      @(negedge clk);
      bus.in_op = OP_DIVU; bus.in_a = 64'd298700; bus.in_b = 64'd17600;
      bus.in_rd = 5'd21; bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (20) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      check("midrst_out_result", bus.out_result, 64'd0);
      check("midrst_out_rd", {59'd0, bus.out_rd}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst_in_ready", {63'd0, bus.in_ready}, 64'd1);
      seen = 0;
      for (int c = 0; c < 70; c++) begin
         @(negedge clk);
         if (bus.out_valid) seen++;
      end
      check("midrst_discarded", 64'(seen), 64'd0);
      v.name = "post_rst_divu"; v.op = OP_DIVU; v.word = 1'b0; v.a = 64'd100; v.b = 64'd7;
      v.rd = 5'd30; v.exp = 64'd14; v.lat = 65;
      run_op(v);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
